// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: datapath widths, fetch FSM states and counter helper.
// The decoder imports this same package so instruction widths stay in lockstep.
package fetch_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    // Saturating increment so the retire counter sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of control, instruction-memory and decoder signals around the fetch unit.
// master = surrounding system (memory, decoder, sequencer); slave = fetch_unit itself.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic                 start;
    logic [PC_W-1:0]      lastAddr;
    logic                 stall;
    logic                 branchEnable;
    logic [PC_W-1:0]      branchTarget;
    logic [PC_W-1:0]      imemAddr;
    logic [INSTR_W-1:0]   imemData;
    logic [INSTR_W-1:0]   instr;
    logic                 instrValid;
    logic                 done;
    logic [CNT_W-1:0]     retired;

    modport master (
        output start, lastAddr, stall, branchEnable, branchTarget, imemData,
        input  imemAddr, instr, instrValid, done, retired
    );

    modport slave (
        input  start, lastAddr, stall, branchEnable, branchTarget, imemData,
        output imemAddr, instr, instrValid, done, retired
    );

endinterface

// File: rtl/fetch_unit_prog_ctr.sv
// Program counter register: load has priority over increment, otherwise holds.
// Increment wraps naturally at the PC width.
module prog_ctr
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            loadEn_i,
    input  logic [PC_W-1:0] loadAddr_i,
    input  logic            incEn_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (loadEn_i) begin
            pc_d = loadAddr_i;
        end else if (incEn_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: runs a program from address 0 to lastAddr, handles
// taken branches with a single squashed bubble, stalls, and counts retired instructions.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.slave  fetchBus
);

    fetch_state_e         state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 instrValid_q, instrValid_d;
    logic [CNT_W-1:0]     retired_q, retired_d;

    logic [PC_W-1:0]      pc;
    logic                 pcLoad;
    logic [PC_W-1:0]      pcLoadAddr;
    logic                 pcInc;
    logic                 branchTaken;

    prog_ctr u_progCtr (
        .clk        (clk),
        .rst_n      (rst_n),
        .loadEn_i   (pcLoad),
        .loadAddr_i (pcLoadAddr),
        .incEn_i    (pcInc),
        .pc_o       (pc)
    );

    // A branch flag only means something while a live instruction sits on instr
    assign branchTaken = instrValid_q & fetchBus.branchEnable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            instrValid_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            instrValid_q <= instrValid_d;
            retired_q    <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        instrValid_d = instrValid_q;
        retired_d    = retired_q;
        pcLoad       = 1'b0;
        pcLoadAddr   = '0;
        pcInc        = 1'b0;

        if (!fetchBus.stall) begin
            if (instrValid_q) begin
                retired_d = satInc(retired_q);
            end

            unique case (state_q)
                IDLE: begin
                    instrValid_d = 1'b0;
                    if (fetchBus.start) begin
                        pcLoad  = 1'b1;
                        state_d = RUN;
                    end
                end

                RUN: begin
                    if (branchTaken) begin
                        pcLoad       = 1'b1;
                        pcLoadAddr   = fetchBus.branchTarget;
                        instrValid_d = 1'b0;
                    end else begin
                        instr_d      = fetchBus.imemData;
                        instrValid_d = 1'b1;
                        pcInc        = 1'b1;
                        if (pc == fetchBus.lastAddr) begin
                            state_d = DRAIN;
                        end
                    end
                end

                // Last instruction is on instr; a taken branch here resumes the program
                DRAIN: begin
                    instrValid_d = 1'b0;
                    if (branchTaken) begin
                        pcLoad     = 1'b1;
                        pcLoadAddr = fetchBus.branchTarget;
                        state_d    = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end

                DONE: begin
                    instrValid_d = 1'b0;
                    if (fetchBus.start) begin
                        pcLoad    = 1'b1;
                        retired_d = '0;
                        state_d   = RUN;
                    end
                end
            endcase
        end
    end

    assign fetchBus.imemAddr   = pc;
    assign fetchBus.instr      = instr_q;
    assign fetchBus.instrValid = instrValid_q;
    assign fetchBus.done       = (state_q == DONE);
    assign fetchBus.retired    = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table with hand-computed results,
// plus a hand-written asynchronous reset sequence in the middle of a run.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;

    int testsRun;
    int testsFailed;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fetchBus (bus)
    );

    typedef struct {
        logic         start;
        logic         stall;
        logic         brEn;
        logic [9:0]   brTgt;
        logic [9:0]   lastAddr;
        logic [9:0]   expAddr;
        logic         expValid;
        logic [8:0]   expInstr;
        logic         expDone;
        logic [15:0]  expRet;
    } vec_t;

    vec_t vecs[$];

    // Program memory contents: a fixed scramble of the address
    function automatic logic [8:0] memWord(input logic [9:0] addr);
        return addr[8:0] ^ 9'h1A5;
    endfunction

    assign bus.imemData = memWord(bus.imemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic start, input logic stall, input logic brEn,
                                input logic [9:0] brTgt, input logic [9:0] lastAddr,
                                input logic [9:0] expAddr, input logic expValid,
                                input logic [9:0] instrAddr, input logic expDone,
                                input logic [15:0] expRet);
        vec_t v;
        v.start    = start;
        v.stall    = stall;
        v.brEn     = brEn;
        v.brTgt    = brTgt;
        v.lastAddr = lastAddr;
        v.expAddr  = expAddr;
        v.expValid = expValid;
        v.expInstr = memWord(instrAddr);
        v.expDone  = expDone;
        v.expRet   = expRet;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.start        = v.start;
        bus.stall        = v.stall;
        bus.branchEnable = v.brEn;
        bus.branchTarget = v.brTgt;
        bus.lastAddr     = v.lastAddr;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("v%0d.imemAddr", idx), 32'(bus.imemAddr), 32'(v.expAddr));
        checkOutput($sformatf("v%0d.instrValid", idx), 32'(bus.instrValid), 32'(v.expValid));
        checkOutput($sformatf("v%0d.done", idx), 32'(bus.done), 32'(v.expDone));
        checkOutput($sformatf("v%0d.retired", idx), 32'(bus.retired), 32'(v.expRet));
        if (v.expValid) begin
            checkOutput($sformatf("v%0d.instr", idx), 32'(bus.instr), 32'(v.expInstr));
        end
    endtask

    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkVector(i, vecs[i]);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Straight line 0..3, then restart from DONE, branch, ignored branch/start, stall
        //            st st br tgt  last  addr v  iA    d  ret
        vecs.push_back(mk(1, 0, 0, 0,   3,   0,  0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   3,   1,  1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   3,   2,  1, 1,   0, 1));
        vecs.push_back(mk(0, 0, 0, 0,   3,   3,  1, 2,   0, 2));
        vecs.push_back(mk(0, 0, 0, 0,   3,   4,  1, 3,   0, 3));
        vecs.push_back(mk(0, 0, 0, 0,   3,   4,  0, 0,   1, 4));
        vecs.push_back(mk(0, 0, 0, 0,   3,   4,  0, 0,   1, 4));
        vecs.push_back(mk(1, 0, 0, 0,   20,  0,  0, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   20,  1,  1, 0,   0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   20,  2,  1, 1,   0, 1));
        vecs.push_back(mk(0, 0, 0, 0,   20,  3,  1, 2,   0, 2));
        vecs.push_back(mk(0, 0, 1, 10,  20,  10, 0, 0,   0, 3));
        vecs.push_back(mk(0, 0, 1, 500, 20,  11, 1, 10,  0, 3));
        vecs.push_back(mk(0, 0, 0, 0,   20,  12, 1, 11,  0, 4));
        vecs.push_back(mk(1, 0, 0, 0,   20,  13, 1, 12,  0, 5));
        vecs.push_back(mk(0, 0, 1, 4,   20,  4,  0, 0,   0, 6));
        vecs.push_back(mk(0, 0, 0, 0,   20,  5,  1, 4,   0, 6));
        vecs.push_back(mk(1, 1, 1, 99,  20,  5,  1, 4,   0, 6));
        vecs.push_back(mk(1, 1, 1, 99,  20,  5,  1, 4,   0, 6));
        vecs.push_back(mk(1, 1, 1, 99,  20,  5,  1, 4,   0, 6));
        vecs.push_back(mk(0, 0, 0, 0,   20,  6,  1, 5,   0, 7));
        vecs.push_back(mk(0, 0, 0, 0,   20,  7,  1, 6,   0, 8));
        // After reset: restart at 0, lastAddr=1, branch from DRAIN to 1023 wraps to 0
        vecs.push_back(mk(1, 0, 0, 0,    1,  0,    0, 0,    0, 0));
        vecs.push_back(mk(0, 0, 0, 0,    1,  1,    1, 0,    0, 0));
        vecs.push_back(mk(0, 0, 0, 0,    1,  2,    1, 1,    0, 1));
        vecs.push_back(mk(0, 0, 1, 1023, 1,  1023, 0, 0,    0, 2));
        vecs.push_back(mk(0, 0, 0, 0,    1,  0,    1, 1023, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,    1,  1,    1, 0,    0, 3));
        vecs.push_back(mk(0, 0, 0, 0,    1,  2,    1, 1,    0, 4));
        vecs.push_back(mk(0, 0, 0, 0,    1,  2,    0, 0,    1, 5));

        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.stall        = 1'b0;
        bus.branchEnable = 1'b0;
        bus.branchTarget = '0;
        bus.lastAddr     = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.imemAddr", 32'(bus.imemAddr), 32'd0);
        checkOutput("reset.instrValid", 32'(bus.instrValid), 32'd0);
        checkOutput("reset.instr", 32'(bus.instr), 32'd0);
        checkOutput("reset.done", 32'(bus.done), 32'd0);
        checkOutput("reset.retired", 32'(bus.retired), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        runVectors(0, 21);

        // Asynchronous reset mid-RUN at pc=7: outputs clear before any further edge
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.imemAddr", 32'(bus.imemAddr), 32'd0);
        checkOutput("midrst.instrValid", 32'(bus.instrValid), 32'd0);
        checkOutput("midrst.instr", 32'(bus.instr), 32'd0);
        checkOutput("midrst.done", 32'(bus.done), 32'd0);
        checkOutput("midrst.retired", 32'(bus.retired), 32'd0);

        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("idle%0d.imemAddr", k), 32'(bus.imemAddr), 32'd0);
            checkOutput($sformatf("idle%0d.instrValid", k), 32'(bus.instrValid), 32'd0);
            checkOutput($sformatf("idle%0d.done", k), 32'(bus.done), 32'd0);
        end

        runVectors(22, vecs.size() - 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port start, input, 1: begin execution at address 0 (sampled in IDLE/DONE only).
REQ-004 SHALL have port lastAddr, input, 10: address of the final program instruction.
REQ-005 SHALL have port stall, input, 1: freeze the pipeline this cycle.
REQ-006 SHALL have port branchEnable, input, 1: decoder's taken-branch flag for the instruction currently on instr.
REQ-007 SHALL have port branchTarget, input, 10: branch destination address, valid with branchEnable.
REQ-008 SHALL have port imemAddr, output, 10: instruction memory address, equal to the PC register.
REQ-009 SHALL have port imemData, input, 9: combinational instruction memory read data for imemAddr.
REQ-010 SHALL have port instr, output, 9: registered instruction word to the decoder.
REQ-011 SHALL have port instrValid, output, 1: instr holds a live, non-squashed instruction.
REQ-012 SHALL have port done, output, 1: program complete.
REQ-013 SHALL have port retired, output, 16: count of retired instructions.

Function
REQ-014 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-015 IDLE: pc=0, instrValid=0, done=0; start=1 -> RUN at the next edge.
REQ-016 RUN fetch, when stall=0 and no branch: instr<=imemData, instrValid<=1, pc<=pc+1 (10-bit, 1023 wraps to 0).
REQ-017 Branch taken when instrValid=1, branchEnable=1, stall=0: pc<=branchTarget and instrValid<=0 (squashes the wrong-path fetch; exactly one bubble).
REQ-018 branchEnable with instrValid=0 SHALL be ignored.
REQ-019 stall=1 SHALL hold pc, instr, instrValid, state and retired unchanged; stall takes priority over branch and start.
REQ-020 Retire event = instrValid=1 and stall=0; retired increments by 1 per event and saturates at 16'hFFFF.
REQ-021 A RUN fetch from pc==lastAddr with no branch SHALL load that instruction and transition to DRAIN.
REQ-022 DRAIN, stall=0: a taken branch -> pc<=branchTarget, instrValid<=0, RUN; otherwise -> instrValid<=0, DONE.
REQ-023 DONE: done=1, instrValid=0, pc held; start=1 -> pc<=0, retired<=0, RUN; done deasserts in the same edge.
REQ-024 start SHALL be ignored in RUN and DRAIN.
REQ-025 done SHALL be a Moore output decoded from state; imemAddr SHALL be driven directly from the pc register.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, pc=0, instr=9'h000, instrValid=0, done=0, retired=0, regardless of the clock.
REQ-027 Reset asserted mid-RUN or mid-DRAIN SHALL discard the in-flight instruction; no retire is counted on that cycle.
REQ-028 After rst_n deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Structure
REQ-029 A shared package fetch_pkg SHALL hold the state enum and the constants PC_W=10, INSTR_W=9 and CNT_W=16.
REQ-030 The instruction encoding widths SHALL come from the same package the decoder uses.
REQ-031 The PC register, with its increment, load and hold behaviour, SHALL be a sub-module named prog_ctr; all else stays in fetch_unit.

Verification
REQ-032 Straight line: lastAddr=3, start pulse, no stall/branch -> imemAddr 0,1,2,3; instrValid high 4 cycles; done=1 on the 6th edge after start; retired=4.
REQ-033 Branch: at instr from addr 2, branchEnable=1, target=10 -> next instrValid=0 (one bubble), imemAddr=10, then 11; addr 3 never retired.
REQ-034 Stall: stall=1 for 3 cycles mid-RUN at pc=5 -> pc, instr and retired frozen; resume at pc=5 with no lost or duplicated instruction.
REQ-035 Wrap: lastAddr=1, branch to 1023 -> next fetch address 0; retired count continues.
REQ-036 Reset: rst_n=0 mid-RUN at pc=7 -> outputs reach reset values before the next edge; start then restarts at address 0.
REQ-037 Restart/ignore: start in RUN has no effect; start in DONE -> retired=0 and fetch restarts at 0.
